// File: rtl/pcpu_mem_host_pkg.sv
// Shared definitions for the PCPU memory host: ISA opcodes, host command
// encodings, run-controller states and the memory write-port payload.
package pcpu_mem_host_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned CMD_W  = 2;
  localparam int unsigned CNT_W  = 16;

  localparam logic [OP_W-1:0] OP_NOP   = 5'b00000;
  localparam logic [OP_W-1:0] OP_HALT  = 5'b00001;
  localparam logic [OP_W-1:0] OP_LOAD  = 5'b00010;
  localparam logic [OP_W-1:0] OP_STORE = 5'b00011;
  localparam logic [OP_W-1:0] OP_SLL   = 5'b00100;
  localparam logic [OP_W-1:0] OP_SLA   = 5'b00101;
  localparam logic [OP_W-1:0] OP_SRL   = 5'b00110;
  localparam logic [OP_W-1:0] OP_SRA   = 5'b00111;
  localparam logic [OP_W-1:0] OP_ADD   = 5'b01000;
  localparam logic [OP_W-1:0] OP_ADDI  = 5'b01001;
  localparam logic [OP_W-1:0] OP_SUB   = 5'b01010;
  localparam logic [OP_W-1:0] OP_SUBI  = 5'b01011;
  localparam logic [OP_W-1:0] OP_CMP   = 5'b01100;
  localparam logic [OP_W-1:0] OP_AND   = 5'b01101;
  localparam logic [OP_W-1:0] OP_OR    = 5'b01110;
  localparam logic [OP_W-1:0] OP_XOR   = 5'b01111;
  localparam logic [OP_W-1:0] OP_LDIH  = 5'b10000;
  localparam logic [OP_W-1:0] OP_ADDC  = 5'b10001;
  localparam logic [OP_W-1:0] OP_SUBC  = 5'b10010;
  localparam logic [OP_W-1:0] OP_JUMP  = 5'b11000;
  localparam logic [OP_W-1:0] OP_JMPR  = 5'b11001;
  localparam logic [OP_W-1:0] OP_BZ    = 5'b11010;
  localparam logic [OP_W-1:0] OP_BNZ   = 5'b11011;
  localparam logic [OP_W-1:0] OP_BN    = 5'b11100;
  localparam logic [OP_W-1:0] OP_BNN   = 5'b11101;
  localparam logic [OP_W-1:0] OP_BC    = 5'b11110;
  localparam logic [OP_W-1:0] OP_BNC   = 5'b11111;

  typedef enum logic [CMD_W-1:0] {
    CMD_WR_IMEM = 2'b00,
    CMD_WR_DMEM = 2'b01,
    CMD_RD_DMEM = 2'b10,
    CMD_RUN     = 2'b11
  } host_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } run_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_wr_t;

  function automatic logic is_op(input logic [DATA_W-1:0] inst, input logic [OP_W-1:0] op);
    return inst[DATA_W-1 -: OP_W] == op;
  endfunction

endpackage

// File: rtl/pcpu_mem_2p.sv
// 256x16 memory with one zero-latency read port and one synchronous write port.
module pcpu_mem_2p
  import pcpu_mem_host_pkg::*;
(
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data_c
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; they survive a core reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/pcpu_mem_host.sv
// Memory responder and run controller for the PCPU core: owns imem/dmem,
// serves host preload/readback and sequences start/enable around a HALT.
module pcpu_mem_host
  import pcpu_mem_host_pkg::*;
#(
  parameter int unsigned     START_CYCLES = 2,
  parameter int unsigned     DRAIN_CYCLES = 4,
  parameter logic [OP_W-1:0] HALT_OP      = OP_HALT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_datain,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_dataout,
  input  logic              d_we,
  output logic [DATA_W-1:0] d_datain,
  output logic              start,
  output logic              enable,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [CMD_W-1:0]  host_cmd,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int unsigned PH_MAX = (START_CYCLES > DRAIN_CYCLES) ? START_CYCLES : DRAIN_CYCLES;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0]  START_LAST = PH_W'(START_CYCLES - 1);
  localparam logic [PH_W-1:0]  DRAIN_LAST = PH_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  run_state_e        state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic              halt_seen_q, halt_seen_d;
  logic              start_q, start_d;
  logic              enable_q, enable_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  count_q, count_d;

  host_cmd_e         cmd;
  logic              host_acc;
  logic              halt_fetch;
  mem_wr_t           imem_wr;
  mem_wr_t           dmem_wr;
  logic [ADDR_W-1:0] dmem_rd_addr;
  logic [DATA_W-1:0] dmem_rd_c;

  assign cmd        = host_cmd_e'(host_cmd);
  assign host_acc   = host_valid & ready_q;
  assign halt_fetch = is_op(i_datain, HALT_OP);

  // imem is host-written only; dmem write port belongs to the core while enabled.
  always_comb begin
    imem_wr.we   = host_acc && (cmd == CMD_WR_IMEM);
    imem_wr.addr = host_addr;
    imem_wr.data = host_wdata;
    if (enable_q) begin
      dmem_wr.we   = d_we;
      dmem_wr.addr = d_addr;
      dmem_wr.data = d_dataout;
    end else begin
      dmem_wr.we   = host_acc && (cmd == CMD_WR_DMEM);
      dmem_wr.addr = host_addr;
      dmem_wr.data = host_wdata;
    end
  end

  // The single dmem read port serves the core when enabled, the host otherwise.
  assign dmem_rd_addr = enable_q ? d_addr : host_addr;
  assign d_datain     = dmem_rd_c;

  pcpu_mem_2p u_imem (
    .clock     (clock),
    .wr_en     (imem_wr.we),
    .wr_addr   (imem_wr.addr),
    .wr_data   (imem_wr.data),
    .rd_addr   (i_addr),
    .rd_data_c (i_datain)
  );

  pcpu_mem_2p u_dmem (
    .clock     (clock),
    .wr_en     (dmem_wr.we),
    .wr_addr   (dmem_wr.addr),
    .wr_data   (dmem_wr.data),
    .rd_addr   (dmem_rd_addr),
    .rd_data_c (dmem_rd_c)
  );

  // Next-state, next-output and host-side datapath.
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    halt_seen_d = halt_seen_q;
    rvalid_d    = 1'b0;
    rdata_d     = rdata_q;
    count_d     = count_q;

    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (host_acc && (cmd == CMD_RUN)) begin
          state_d     = ST_START;
          ph_d        = '0;
          halt_seen_d = 1'b0;
        end
      end
      ST_START: begin
        // A HALT fetched during start-up is remembered and honoured afterwards.
        halt_seen_d = halt_seen_q | halt_fetch;
        if (ph_q == START_LAST) begin
          ph_d    = '0;
          state_d = (halt_seen_q | halt_fetch) ? ST_DRAIN : ST_RUN;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_RUN: begin
        if (halt_fetch) begin
          state_d = ST_DRAIN;
          ph_d    = '0;
        end
      end
      ST_DRAIN: begin
        if (ph_q == DRAIN_LAST) begin
          state_d = ST_HALTED;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ph_d    = '0;
      end
    endcase

    if (host_acc && (cmd == CMD_RD_DMEM)) begin
      rvalid_d = 1'b1;
      rdata_d  = dmem_rd_c;
    end

    if (host_acc && (cmd == CMD_RUN)) begin
      count_d = '0;
    end else if (enable_q && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end

    start_d  = (state_d == ST_START);
    enable_d = (state_d == ST_START) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
    busy_d   = enable_d;
    ready_d  = !enable_d;
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ph_q        <= '0;
      halt_seen_q <= 1'b0;
      start_q     <= 1'b0;
      enable_q    <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      halt_seen_q <= halt_seen_d;
      start_q     <= start_d;
      enable_q    <= enable_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      count_q     <= count_d;
    end
  end

  assign start       = start_q;
  assign enable      = enable_q;
  assign host_ready  = ready_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign host_rvalid = rvalid_q;
  assign host_rdata  = rdata_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_pcpu_mem_host.sv
// Scoreboard bench for pcpu_mem_host with a tiny instruction-level core stand-in.
module tb_pcpu_mem_host;
  import pcpu_mem_host_pkg::*;

  localparam int unsigned START_N = 2;
  localparam int unsigned DRAIN_N = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  i_addr = '0;
  logic [15:0] i_datain;
  logic [7:0]  d_addr = '0;
  logic [15:0] d_dataout = '0;
  logic        d_we = 1'b0;
  logic [15:0] d_datain;
  logic        start, enable;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [1:0]  host_cmd = '0;
  logic [7:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic [15:0] host_rdata;
  logic        host_rvalid;
  logic        busy, halted;
  logic [15:0] cycle_count;

  pcpu_mem_host #(.START_CYCLES(START_N), .DRAIN_CYCLES(DRAIN_N), .HALT_OP(OP_HALT)) dut (
    .clock(clock), .reset(reset),
    .i_addr(i_addr), .i_datain(i_datain),
    .d_addr(d_addr), .d_dataout(d_dataout), .d_we(d_we), .d_datain(d_datain),
    .start(start), .enable(enable),
    .host_valid(host_valid), .host_ready(host_ready), .host_cmd(host_cmd),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .busy(busy), .halted(halted), .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [7:0]  written[$];
  logic [15:0] model_dmem [256];
  logic [15:0] regs [8];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          en_cnt = 0;
  int          st_cnt = 0;
  logic [7:0]  pc = '0;
  logic        fixed = 1'b0;
  logic [7:0]  fixed_addr = '0;
  logic        poke = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Enabled/start cycle counters, observed mid-cycle.
  always @(negedge clock) begin
    if (enable) en_cnt++;
    if (start) st_cnt++;
  end

  // Monitor: every read-data pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset && host_rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_unexpected: got data %0h with nothing outstanding", host_rdata);
      end else begin
        e = exp_q.pop_front();
        chk("host_rdata", 32'(host_rdata), 32'(e.data));
        chk("rvalid_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Core stand-in: executes LOAD/ADD/STORE/HALT one instruction per enabled cycle.
  initial begin
    logic [15:0] inst;
    for (int r = 0; r < 8; r++) regs[r] = '0;
    forever begin
      @(negedge clock);
      d_we = 1'b0;
      if (poke) begin
        d_we = 1'b1;
        d_addr = 8'd0;
        d_dataout = 16'hFFFF;
      end else if (enable) begin
        i_addr = fixed ? fixed_addr : pc;
        #1;
        inst = i_datain;
        if (!fixed) begin
          case (inst[15:11])
            OP_LOAD: begin
              d_addr = {4'b0, inst[3:0]};
              #1;
              chk("core_load", 32'(d_datain), 32'(model_dmem[d_addr]));
              regs[inst[10:8]] = d_datain;
            end
            OP_ADD: regs[inst[10:8]] = regs[inst[6:4]] + regs[inst[2:0]];
            OP_STORE: begin
              d_addr = {4'b0, inst[3:0]};
              d_dataout = regs[inst[10:8]];
              d_we = 1'b1;
            end
            default: ;
          endcase
          if (inst[15:11] != OP_HALT) pc = pc + 8'd1;
        end
      end
    end
  end

  // Issue one command at a negedge; returns at the negedge after acceptance.
  task automatic do_cmd(input logic [1:0] cmd, input logic [7:0] addr, input logic [15:0] wdata);
    int n = 0;
    host_valid = 1'b1;
    host_cmd   = cmd;
    host_addr  = addr;
    host_wdata = wdata;
    while (!host_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!host_ready) begin
      checks++;
      errors++;
      $display("FAIL host_ready_timeout: cmd %0d still not accepted after %0d cycles", cmd, n);
      host_valid = 1'b0;
      return;
    end
    case (cmd)
      2'b01: begin
        model_dmem[addr] = wdata;
        written.push_back(addr);
      end
      2'b10: exp_q.push_back('{data: model_dmem[addr], cyc: cyc + 1});
      2'b11: begin
        pc = '0;
        en_cnt = 0;
        st_cnt = 0;
      end
      default: ;
    endcase
    @(posedge clock);
    @(negedge clock);
    host_valid = 1'b0;
  endtask

  task automatic run_cmd();
    do_cmd(2'b11, 8'd0, 16'd0);
    chk("run_enable_latency", 32'(enable), 32'd1);
    chk("run_start", 32'(start), 32'd1);
    chk("run_ready_low", 32'(host_ready), 32'd0);
    chk("run_busy", 32'(busy), 32'd1);
  endtask

  task automatic wait_halted(input int max);
    int n = 0;
    while (!halted && n < max) begin
      @(negedge clock);
      n++;
    end
    chk("halted_reached", 32'(halted), 32'd1);
  endtask

  initial begin
    logic [15:0] prog [11];
    logic [7:0]  a;
    logic [15:0] w;
    int          n;

    prog[0]  = 16'h1100;                  // LOAD  gr1,[0]
    prog[1]  = 16'h1201;                  // LOAD  gr2,[1]
    prog[2]  = 16'h0000;
    prog[3]  = 16'h0000;
    prog[4]  = 16'h0000;
    prog[5]  = 16'h4312;                  // ADD   gr3,gr1,gr2
    prog[6]  = 16'h0000;
    prog[7]  = 16'h0000;
    prog[8]  = 16'h0000;
    prog[9]  = 16'h1B02;                  // STORE gr3,[2]
    prog[10] = {OP_HALT, 11'b0};

    repeat (3) @(negedge clock);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_host_ready", 32'(host_ready), 32'd1);
    chk("rst_rvalid", 32'(host_rvalid), 32'd0);
    chk("rst_rdata", 32'(host_rdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_cycle_count", 32'(cycle_count), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Program run: dmem[2] = dmem[0] + dmem[1].
    for (int i = 0; i < 11; i++) do_cmd(2'b00, 8'(i), prog[i]);
    do_cmd(2'b01, 8'd0, 16'h00AB);
    do_cmd(2'b01, 8'd1, 16'h3C00);
    run_cmd();
    wait_halted(200);
    chk("prog_busy_after", 32'(busy), 32'd0);
    model_dmem[2] = model_dmem[0] + model_dmem[1];
    do_cmd(2'b10, 8'd2, 16'd0);

    // Random host traffic, including back-to-back write then read of one address.
    for (int i = 0; i < 40; i++) begin
      n = int'($urandom_range(0, 3));
      a = 8'($urandom_range(16, 255));
      w = 16'($urandom);
      if (n < 2 || written.size() == 0) begin
        do_cmd(2'b01, a, w);
      end else if (n == 2) begin
        do_cmd(2'b10, written[$urandom_range(0, written.size() - 1)], 16'd0);
      end else begin
        do_cmd(2'b01, a, w);
        do_cmd(2'b10, a, 16'd0);
      end
    end

    // Immediate HALT: minimum-length run, re-entered from HALTED.
    do_cmd(2'b00, 8'd0, {OP_HALT, 11'b0});
    run_cmd();
    wait_halted(50);
    chk("min_start_cycles", 32'(st_cnt), 32'(START_N));
    chk("min_enable_cycles", 32'(en_cnt), 32'(START_N + DRAIN_N));
    chk("min_cycle_count", 32'(cycle_count), 32'(START_N + DRAIN_N));
    chk("min_enable_off", 32'(enable), 32'd0);
    chk("min_ready_back", 32'(host_ready), 32'd1);
    repeat (3) @(negedge clock);
    chk("min_count_holds", 32'(cycle_count), 32'(START_N + DRAIN_N));

    // Core store strobe while disabled must not reach dmem.
    poke = 1'b1;
    repeat (3) @(negedge clock);
    poke = 1'b0;
    @(negedge clock);
    do_cmd(2'b10, 8'd0, 16'd0);

    // Endless run: host locked out, counter saturates, then reset mid-run.
    do_cmd(2'b01, 8'd5, 16'h1234);
    do_cmd(2'b00, 8'd200, 16'h0000);
    fixed = 1'b1;
    fixed_addr = 8'd200;
    run_cmd();
    repeat (100) @(posedge clock);
    #1;
    chk("count_100", 32'(cycle_count), 32'd100);
    @(negedge clock);
    host_valid = 1'b1;
    host_cmd   = 2'b01;
    host_addr  = 8'd5;
    host_wdata = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      chk("busy_ready_low", 32'(host_ready), 32'd0);
      @(negedge clock);
    end
    host_valid = 1'b0;
    repeat (65500) @(posedge clock);
    #1;
    chk("count_saturated", 32'(cycle_count), 32'hFFFF);
    chk("still_enabled", 32'(enable), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("arst_enable", 32'(enable), 32'd0);
    chk("arst_start", 32'(start), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_halted", 32'(halted), 32'd0);
    chk("arst_ready", 32'(host_ready), 32'd1);
    chk("arst_count", 32'(cycle_count), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    fixed = 1'b0;
    @(negedge clock);
    do_cmd(2'b10, 8'd0, 16'd0);
    do_cmd(2'b10, 8'd5, 16'd0);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL read_drain: %0d reads never answered", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
